pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_pkg.sv | 32 +++
 rtl/sat_counter.sv | 18 +
 rtl/pipe_stage_reg.sv | 103 ++++++++++
 tb/tb_pipe_stage_reg.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: skid-stage state encoding and the ID/EX payload layout.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stage_state_e;

  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;
  localparam int IMM_W   = 32;
  localparam int RS1_W   = 32;
  localparam int RS2_W   = 32;

  // Fields packed LSB-first in the order rs2, rs1, imm, instr, pc.
  localparam int RS2_LSB   = 0;
  localparam int RS1_LSB   = RS2_LSB + RS2_W;
  localparam int IMM_LSB   = RS1_LSB + RS1_W;
  localparam int INSTR_LSB = IMM_LSB + IMM_W;
  localparam int PC_LSB    = INSTR_LSB + INSTR_W;
  localparam int IDEX_W    = PC_LSB + PC_W;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic [IMM_W-1:0]   imm;
    logic [RS1_W-1:0]   rs1;
    logic [RS2_W-1:0]   rs2;
  } idex_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (inc && (count != {W{1'b1}}))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register: single-entry (SKID=0) or registered-ready skid stage (SKID=1).
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SKID  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [15:0]      stall_count
);

  generate
    if (SKID != 0) begin : g_skid
      stage_state_e     state;
      logic [WIDTH-1:0] main_q, skid_q;
      logic             rdy_q;
      logic             in_fire, out_fire;

      assign in_fire   = in_valid & rdy_q;
      assign out_fire  = (state != EMPTY) & out_ready;
      assign out_valid = (state != EMPTY);
      assign in_ready  = rdy_q;
      assign out_data  = main_q;

      // rdy_q tracks (next state != TWO) so in_ready never sees out_ready.
      always_ff @(posedge clk) begin
        if (reset) begin
          state  <= EMPTY;
          rdy_q  <= 1'b1;
          main_q <= '0;
          skid_q <= '0;
        end else if (flush) begin
          state <= EMPTY;
          rdy_q <= 1'b1;
        end else begin
          case (state)
            EMPTY: if (in_fire) begin
              state  <= ONE;
              main_q <= in_data;
            end
            ONE: begin
              if (in_fire && !out_fire) begin
                state  <= TWO;
                skid_q <= in_data;
                rdy_q  <= 1'b0;
              end else if (out_fire && !in_fire) begin
                state <= EMPTY;
              end else if (in_fire && out_fire) begin
                main_q <= in_data;
              end
            end
            TWO: if (out_fire) begin
              state  <= ONE;
              main_q <= skid_q;
              rdy_q  <= 1'b1;
            end
            default: begin
              state <= EMPTY;
              rdy_q <= 1'b1;
            end
          endcase
        end
      end
    end else begin : g_single
      logic             vld_q;
      logic [WIDTH-1:0] data_q;

      assign in_ready  = !vld_q | out_ready;
      assign out_valid = vld_q;
      assign out_data  = data_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          vld_q  <= 1'b0;
          data_q <= '0;
        end else if (flush) begin
          vld_q <= 1'b0;
        end else if (in_valid && in_ready) begin
          vld_q  <= 1'b1;
          data_q <= in_data;
        end else if (out_ready) begin
          vld_q <= 1'b0;
        end
      end
    end
  endgenerate

  sat_counter #(.W(16)) u_stall (
    .clk   (clk),
    .reset (reset),
    .inc   (out_valid & ~out_ready),
    .count (stall_count)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed table-driven bench for both SKID variants of pipe_stage_reg.
module tb_pipe_stage_reg;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         flush1, iv1, or1, flush0, iv0, or0;
  logic [W-1:0] d1, d0;
  logic         ir1, ov1, ir0, ov0;
  logic [W-1:0] od1, od0;
  logic [15:0]  st1, st0;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.WIDTH(W), .SKID(1)) u1 (
    .clk(clk), .reset(reset), .flush(flush1), .in_valid(iv1), .in_ready(ir1),
    .in_data(d1), .out_valid(ov1), .out_ready(or1), .out_data(od1), .stall_count(st1));

  pipe_stage_reg #(.WIDTH(W), .SKID(0)) u0 (
    .clk(clk), .reset(reset), .flush(flush0), .in_valid(iv0), .in_ready(ir0),
    .in_data(d0), .out_valid(ov0), .out_ready(or0), .out_data(od0), .stall_count(st0));

  typedef struct {
    bit          sel;   // 1 = SKID=1 instance, 0 = SKID=0 instance
    bit          rst, fl, iv;
    logic [W-1:0] d;
    bit          ordy;
    bit          eir;   // in_ready before the edge
    bit          eov;   // after the edge
    logic [W-1:0] eod;
    logic [15:0] est;
    string       name;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic add(input bit sel, input bit rst, input bit fl, input bit iv, input logic [W-1:0] d,
                     input bit ordy, input bit eir, input bit eov, input logic [W-1:0] eod,
                     input logic [15:0] est, input string name);
    vec_t v;
    v.sel = sel; v.rst = rst; v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy;
    v.eir = eir; v.eov = eov; v.eod = eod; v.est = est; v.name = name;
    tbl.push_back(v);
  endtask

  task automatic idle();
    reset = 0; flush1 = 0; iv1 = 0; d1 = '0; or1 = 1; flush0 = 0; iv0 = 0; d0 = '0; or0 = 1;
  endtask

  task automatic apply(input vec_t v);
    idle();
    reset = v.rst;
    if (v.sel) begin flush1 = v.fl; iv1 = v.iv; d1 = v.d; or1 = v.ordy; end
    else       begin flush0 = v.fl; iv0 = v.iv; d0 = v.d; or0 = v.ordy; end
    #1;
    chk({v.name, ".in_ready"}, v.sel ? ir1 : ir0, v.eir);
    @(posedge clk); #1;
    chk({v.name, ".out_valid"}, v.sel ? ov1 : ov0, v.eov);
    chk({v.name, ".out_data"}, v.sel ? od1 : od0, v.eod);
    chk({v.name, ".stall"}, v.sel ? st1 : st0, v.est);
  endtask

  initial begin
    // SKID=1 streaming: one beat per cycle, 1-cycle latency
    for (int i = 0; i < 16; i++)
      add(1, 0, 0, 1, W'(16'h10 + i), 1, 1, 1, W'(16'h10 + i), 0, $sformatf("s1_stream%0d", i));
    add(1, 0, 0, 0, 0, 1, 1, 0, 16'h1F, 0, "s1_drain");
    // SKID=1 backpressure: A,B taken, C held while in TWO
    add(1, 0, 0, 1, 16'hA, 0, 1, 1, 16'hA, 0, "s1_bp_a");
    add(1, 0, 0, 1, 16'hB, 0, 1, 1, 16'hA, 1, "s1_bp_b");
    add(1, 0, 0, 1, 16'hC, 0, 0, 1, 16'hA, 2, "s1_bp_c_held");
    add(1, 0, 0, 1, 16'hC, 1, 0, 1, 16'hB, 2, "s1_bp_out_a");
    add(1, 0, 0, 1, 16'hC, 1, 1, 1, 16'hC, 2, "s1_bp_out_b");
    add(1, 0, 0, 0, 0,     1, 1, 0, 16'hC, 2, "s1_bp_out_c");
    // SKID=1 flush in TWO (0x55 offered) and in ONE (0x55 fires but is discarded)
    add(1, 0, 0, 1, 16'h21, 0, 1, 1, 16'h21, 2, "s1_fl_fill1");
    add(1, 0, 0, 1, 16'h22, 0, 1, 1, 16'h21, 3, "s1_fl_fill2");
    add(1, 0, 1, 1, 16'h55, 0, 0, 0, 16'h21, 4, "s1_fl_two");
    add(1, 0, 0, 1, 16'h23, 0, 1, 1, 16'h23, 4, "s1_fl_refill");
    add(1, 0, 1, 1, 16'h55, 0, 1, 0, 16'h23, 5, "s1_fl_one");
    add(1, 0, 0, 0, 0,      1, 1, 0, 16'h23, 5, "s1_fl_idle");
    add(1, 0, 0, 1, 16'h66, 1, 1, 1, 16'h66, 5, "s1_fl_next");
    add(1, 0, 0, 0, 0,      1, 1, 0, 16'h66, 5, "s1_fl_drain");
    // SKID=0 streaming
    for (int i = 0; i < 4; i++)
      add(0, 0, 0, 1, W'(16'h40 + i), 1, 1, 1, W'(16'h40 + i), 0, $sformatf("s0_stream%0d", i));
    add(0, 0, 0, 0, 0, 1, 1, 0, 16'h43, 0, "s0_drain");
    // SKID=0 backpressure: only A held, in_ready follows out_ready combinationally
    add(0, 0, 0, 1, 16'hA, 0, 1, 1, 16'hA, 0, "s0_bp_a");
    add(0, 0, 0, 1, 16'hB, 0, 0, 1, 16'hA, 1, "s0_bp_b_held");
    add(0, 0, 0, 1, 16'hB, 0, 0, 1, 16'hA, 2, "s0_bp_b_held2");
    add(0, 0, 0, 1, 16'hB, 1, 1, 1, 16'hB, 2, "s0_bp_out_a");
    add(0, 0, 0, 1, 16'hC, 1, 1, 1, 16'hC, 2, "s0_bp_out_b");
    add(0, 0, 0, 0, 0,     1, 1, 0, 16'hC, 2, "s0_bp_out_c");
    // SKID=0 flush
    add(0, 0, 0, 1, 16'h50, 0, 1, 1, 16'h50, 2, "s0_fl_fill");
    add(0, 0, 1, 1, 16'h55, 0, 0, 0, 16'h50, 3, "s0_fl");
    add(0, 0, 0, 1, 16'h51, 1, 1, 1, 16'h51, 3, "s0_fl_next");
    // SKID=1 reset in the middle of a transfer discards both held beats
    add(1, 0, 0, 1, 16'h31, 0, 1, 1, 16'h31, 5, "s1_mr_fill1");
    add(1, 0, 0, 1, 16'h32, 0, 1, 1, 16'h31, 6, "s1_mr_fill2");
    add(1, 1, 0, 1, 16'h33, 0, 0, 0, 16'h0,  0, "s1_mr_reset");
    add(1, 0, 0, 0, 0,      1, 1, 0, 16'h0,  0, "s1_mr_after");

    idle();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.s1_out_valid", ov1, 0);
    chk("rst.s1_in_ready", ir1, 1);
    chk("rst.s1_out_data", od1, 0);
    chk("rst.s1_stall", st1, 0);
    chk("rst.s0_out_valid", ov0, 0);
    chk("rst.s0_in_ready", ir0, 1);
    chk("rst.s0_out_data", od0, 0);
    chk("rst.s0_stall", st0, 0);
    reset = 0;

    foreach (tbl[i]) apply(tbl[i]);

    // Stall counter saturation, then flush leaves it pinned
    idle();
    iv1 = 1; d1 = 16'h77; or1 = 0;
    @(posedge clk); #1;
    iv1 = 0;
    repeat (70000) @(posedge clk);
    #1;
    chk("sat.stall", st1, 16'hFFFF);
    chk("sat.out_valid", ov1, 1);
    chk("sat.out_data", od1, 16'h77);
    flush1 = 1;
    @(posedge clk); #1;
    flush1 = 0;
    chk("sat.flush_valid", ov1, 0);
    chk("sat.flush_stall", st1, 16'hFFFF);
    @(posedge clk); #1;
    chk("sat.after_stall", st1, 16'hFFFF);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
